// File: rtl/calc_serial_alu_ctrl_pkg.sv
// Shared encodings for the bit-serial calculator ALU: operation codes and sequencer states.
package calc_serial_alu_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_ILL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ADD   = 2'b01,
    S_SHIFT = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/calc_serial_alu_ctrl_serial_adder_slice.sv
// One-bit full adder built from two half adders, with a registered carry that can be
// preloaded (carry-in for subtract / iteration start) or advanced bit by bit.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_slice (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cin_load,
  input  logic cin_val,
  input  logic x,
  input  logic y,
  output logic sum,
  output logic cout,
  output logic carry
);
  logic s1, c1, c2;

  half_adder ha0 (.x(x),  .y(y),     .s(s1),  .c(c1));
  half_adder ha1 (.x(s1), .y(carry), .s(sum), .c(c2));

  assign cout = c1 | c2;

  // Load wins over enable so a new operation or iteration always starts from a known carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        carry <= 1'b0;
    else if (cin_load) carry <= cin_val;
    else if (en)       carry <= cout;
  end
endmodule

// File: rtl/calc_serial_alu_ctrl.sv
// Sequencer that time-shares one serial adder slice for WIDTH-bit add, subtract and
// unsigned shift-add multiply, with a start/busy/done handshake.
module calc_serial_alu_ctrl
  import calc_serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               overflow,
  output logic               err
);
  localparam int CW = $clog2(WIDTH + 1);

  state_e             state, state_nxt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   ra, rb;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      bit_cnt, iter_cnt;
  logic               accept, is_mul, last_bit, last_iter;
  logic               x, y, sum, cout, carry;

  assign accept    = (state == S_IDLE) && start;
  assign is_mul    = (op_r == OP_MUL);
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
  assign last_iter = (iter_cnt == CW'(WIDTH - 1));
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // Multiply accumulates into the upper half of acc; the multiplicand in ra rotates so it
  // is intact again after every WIDTH-bit pass.
  assign x = is_mul ? acc[WIDTH] : ra[0];
  assign y = is_mul ? (ra[0] & rb[0]) : rb[0];

  serial_adder_slice u_slice (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state == S_ADD),
    .cin_load (accept || (state == S_SHIFT)),
    .cin_val  (accept ? op[0] : 1'b0),
    .x        (x),
    .y        (y),
    .sum      (sum),
    .cout     (cout),
    .carry    (carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (op == OP_ILL) ? S_DONE : S_ADD;
      S_ADD:   if (last_bit) state_nxt = is_mul ? S_SHIFT : S_DONE;
      S_SHIFT: state_nxt = last_iter ? S_DONE : S_ADD;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= 2'b00;
      ra        <= '0;
      rb        <= '0;
      acc       <= '0;
      bit_cnt   <= '0;
      iter_cnt  <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_r     <= op;
          ra       <= a;
          rb       <= (op == OP_SUB) ? ~b : b;
          acc      <= '0;
          bit_cnt  <= '0;
          iter_cnt <= '0;
          err      <= 1'b0;
          if (op == OP_ILL) begin
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            err       <= 1'b1;
          end
        end
        S_ADD: begin
          ra  <= is_mul ? {ra[0], ra[WIDTH-1:1]} : (ra >> 1);
          rb  <= is_mul ? rb : (rb >> 1);
          acc[2*WIDTH-1:WIDTH] <= {sum, acc[2*WIDTH-1:WIDTH+1]};
          bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
          // On the MSB, carry holds the carry into the MSB and cout the carry out of it.
          if (last_bit && !is_mul) begin
            result    <= {{WIDTH{1'b0}}, sum, acc[2*WIDTH-1:WIDTH+1]};
            carry_out <= cout ^ op_r[0];
            overflow  <= carry ^ cout;
          end
        end
        S_SHIFT: begin
          acc      <= {carry, acc[2*WIDTH-1:1]};
          rb       <= rb >> 1;
          iter_cnt <= last_iter ? '0 : iter_cnt + 1'b1;
          if (last_iter) begin
            result    <= {carry, acc[2*WIDTH-1:1]};
            carry_out <= 1'b0;
            overflow  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
